// File: rtl/interval_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// interval_pulse_gen_pkg
// Shared definitions for the interval pulse generator and the start/stop
// cycle counter bench that it drives.
//   - BIT_SZ_DEFAULT : default width of the programmed interval
//   - ST_*           : 2-bit sequencer state encodings
//   - pulse_t        : bundle of the registered handshake outputs
// -----------------------------------------------------------------------------
package interval_pulse_gen_pkg;

   localparam int BIT_SZ_DEFAULT = 16;
   localparam int STATE_W        = 2;

   localparam logic [STATE_W-1:0] ST_IDLE   = 2'b00;
   localparam logic [STATE_W-1:0] ST_WAIT   = 2'b01;
   localparam logic [STATE_W-1:0] ST_FINISH = 2'b10;

   typedef struct packed {
      logic start;
      logic stop;
      logic busy;
      logic done;
      logic aborted;
   } pulse_t;

   localparam pulse_t PULSE_CLEAR = '{
      start:   1'b0,
      stop:    1'b0,
      busy:    1'b0,
      done:    1'b0,
      aborted: 1'b0
   };

endpackage : interval_pulse_gen_pkg

// File: rtl/interval_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// interval_pulse_gen_if
// Request/response bundle between a sequencing master (lab controller or
// bench) and the interval pulse generator.
//   go, abort, interval          : master -> generator
//   start, stop, busy, done,
//   aborted                      : generator -> master / counter
// -----------------------------------------------------------------------------
interface interval_pulse_gen_if
   import interval_pulse_gen_pkg::*;
#(
   parameter int BIT_SZ = BIT_SZ_DEFAULT
);

   logic              go;
   logic              abort;
   logic [BIT_SZ-1:0] interval;
   logic              start;
   logic              stop;
   logic              busy;
   logic              done;
   logic              aborted;

   modport master (
      output go,
      output abort,
      output interval,
      input  start,
      input  stop,
      input  busy,
      input  done,
      input  aborted
   );

   modport slave (
      input  go,
      input  abort,
      input  interval,
      output start,
      output stop,
      output busy,
      output done,
      output aborted
   );

endinterface : interval_pulse_gen_if

// File: rtl/loadable_down_counter.sv
// -----------------------------------------------------------------------------
// loadable_down_counter
// Down-counter holding the cycles still to wait before stop. It saturates at
// zero, so the longest interval never wraps.
//   clock      : rising-edge clock
//   reset_n    : synchronous active-low reset (count -> 0)
//   load       : capture load_value (has priority over enable)
//   enable     : decrement by one when non-zero
//   load_value : value captured on load
//   zero       : registered flag, high while the count is zero
// -----------------------------------------------------------------------------
module loadable_down_counter
   import interval_pulse_gen_pkg::*;
#(
   parameter int BIT_SZ = BIT_SZ_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load,
   input  logic              enable,
   input  logic [BIT_SZ-1:0] load_value,
   output logic              zero
);

   localparam logic [BIT_SZ-1:0] CNT_ZERO = {BIT_SZ{1'b0}};
   localparam logic [BIT_SZ-1:0] CNT_ONE  = {{(BIT_SZ-1){1'b0}}, 1'b1};

   logic [BIT_SZ-1:0] count_q;
   logic [BIT_SZ-1:0] count_d;
   logic              zero_q;
   logic              zero_d;

   // Next count: load wins, otherwise saturating decrement.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (enable && (count_q != CNT_ZERO)) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
      // Flag follows the next value so it is valid the cycle after a load.
      zero_d = (count_d == CNT_ZERO);
   end

   // Count and zero-flag registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_q <= CNT_ZERO;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_q  <= zero_d;
      end
   end

   assign zero = zero_q;

endmodule : loadable_down_counter

// File: rtl/interval_pulse_gen.sv
// -----------------------------------------------------------------------------
// interval_pulse_gen
// On an accepted go, emits a one-cycle start pulse and then a one-cycle stop
// pulse spaced so that a start/stop counter latches exactly the programmed
// interval. A done pulse closes every sequence; aborted reports that abort
// cut it short and stays set until the next accepted go.
//   clock        : rising-edge clock
//   reset_n      : synchronous active-low reset, beats every other input
//   bus.go       : start request, looked at only when idle
//   bus.abort    : early stop request, looked at only while waiting
//   bus.interval : cycle count to be read by the counter, captured with go
//   bus.start    : registered start pulse
//   bus.stop     : registered stop pulse
//   bus.busy     : high from accepted go until the sequence finishes
//   bus.done     : registered one-cycle completion pulse
//   bus.aborted  : sequence ended by abort
// -----------------------------------------------------------------------------
module interval_pulse_gen
   import interval_pulse_gen_pkg::*;
#(
   parameter int BIT_SZ = BIT_SZ_DEFAULT
) (
   input  logic               clock,
   input  logic               reset_n,
   interval_pulse_gen_if.slave bus
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   pulse_t             pulse_q;
   pulse_t             pulse_d;
   logic               cnt_load_s;
   logic               cnt_en_s;
   logic               cnt_zero_s;

   // Remaining-cycle counter; loaded with the interval on accepted go.
   loadable_down_counter #(
      .BIT_SZ (BIT_SZ)
   ) u_remaining (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (cnt_load_s),
      .enable     (cnt_en_s),
      .load_value (bus.interval),
      .zero       (cnt_zero_s)
   );

   // Sequencer next-state and pulse logic.
   always_comb begin
      state_d    = state_q;
      pulse_d    = pulse_q;
      cnt_load_s = 1'b0;
      cnt_en_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pulse_d.start = 1'b0;
            pulse_d.stop  = 1'b0;
            pulse_d.busy  = 1'b0;
            pulse_d.done  = 1'b0;
            if (bus.go) begin
               cnt_load_s      = 1'b1;
               pulse_d.start   = 1'b1;
               pulse_d.busy    = 1'b1;
               pulse_d.aborted = 1'b0;
               state_d         = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            pulse_d.start = 1'b0;
            // Abort freezes the count; it takes effect even when zero is reached.
            if (bus.abort) begin
               pulse_d.stop    = 1'b1;
               pulse_d.aborted = 1'b1;
               state_d         = ST_FINISH;
            end else if (cnt_zero_s) begin
               pulse_d.stop = 1'b1;
               state_d      = ST_FINISH;
            end else begin
               cnt_en_s = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_FINISH: begin
            pulse_d.stop = 1'b0;
            pulse_d.busy = 1'b0;
            pulse_d.done = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            // Unreachable encoding: fall back to a clean idle.
            pulse_d = PULSE_CLEAR;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output pulse registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         pulse_q <= PULSE_CLEAR;
      end else begin
         state_q <= state_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.start   = pulse_q.start;
   assign bus.stop    = pulse_q.stop;
   assign bus.busy    = pulse_q.busy;
   assign bus.done    = pulse_q.done;
   assign bus.aborted = pulse_q.aborted;

endmodule : interval_pulse_gen

// File: tb/tb_interval_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_interval_pulse_gen
// Directed scenarios followed by random traffic. The reference model tracks
// each sequence only by the edge index of the accepted go (g_m) and of the
// stop decision (e_m), and derives every expected output from those numbers.
// An attached start/stop counter is emulated by measuring start-to-stop
// distance on the DUT outputs.
// -----------------------------------------------------------------------------
module tb_interval_pulse_gen;

   localparam int W = 16;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   interval_pulse_gen_if #(.BIT_SZ(W)) bus ();

   interval_pulse_gen #(
      .BIT_SZ (W)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   int checks     = 0;
   int errors     = 0;
   int t_cyc      = 0;
   int g_m        = -10;
   int e_m        = -10;
   bit ab_m       = 1'b0;
   int meas_start = -1;
   int last_meas  = -1;
   int n_starts   = 0;

   // Single comparison point for the whole bench.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, t_cyc);
      end
   endtask

   // One clock: drive inputs on the falling edge, advance the model on the
   // rising edge, compare just after it.
   task automatic step(input logic rn, input logic g, input logic a, input logic [W-1:0] n);
      int tt;
      @(negedge clock);
      reset_n      = rn;
      bus.go       = g;
      bus.abort    = a;
      bus.interval = n;
      @(posedge clock);
      t_cyc++;
      tt = t_cyc;
      if (!rn) begin
         g_m        = -10;
         e_m        = -10;
         ab_m       = 1'b0;
         meas_start = -1;
      end else if ((tt >= g_m + 1) && (tt <= e_m) && a) begin
         e_m  = tt;
         ab_m = 1'b1;
      end else if ((tt >= e_m + 2) && g) begin
         g_m  = tt;
         e_m  = tt + int'(n) + 1;
         ab_m = 1'b0;
      end
      #1;
      check_eq("start",   32'(bus.start),   32'(tt == g_m));
      check_eq("stop",    32'(bus.stop),    32'(tt == e_m));
      check_eq("busy",    32'(bus.busy),    32'((tt >= g_m) && (tt <= e_m)));
      check_eq("done",    32'(bus.done),    32'(tt == e_m + 1));
      check_eq("aborted", 32'(bus.aborted), 32'(ab_m));
      if (bus.start === 1'b1) begin
         meas_start = tt;
         n_starts++;
      end
      if ((bus.stop === 1'b1) && (meas_start >= 0)) begin
         last_meas = tt - meas_start - 1;
         check_eq("counter_count", 32'(last_meas), 32'(e_m - g_m - 1));
         meas_start = -1;
      end
   endtask

   // Idle cycles with a wandering interval that must have no effect.
   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         step(1'b1, 1'b0, 1'b0, W'($urandom));
      end
   endtask

   initial begin
      bus.go       = 1'b0;
      bus.abort    = 1'b0;
      bus.interval = {W{1'b0}};

      // Reset state.
      step(1'b0, 1'b0, 1'b0, 16'd0);
      step(1'b0, 1'b1, 1'b1, 16'd9);

      // Basic interval of 5.
      step(1'b1, 1'b1, 1'b0, 16'd5);
      idle(10);
      check_eq("count_n5", 32'(last_meas), 32'd5);

      // Zero interval.
      step(1'b1, 1'b1, 1'b0, 16'd0);
      idle(5);
      check_eq("count_n0", 32'(last_meas), 32'd0);

      // Longest interval, no wrap.
      step(1'b1, 1'b1, 1'b0, 16'hFFFF);
      idle(65540);
      check_eq("count_max", 32'(last_meas), 32'h0000_FFFF);

      // Abort on the tenth edge after go.
      step(1'b1, 1'b1, 1'b0, 16'd100);
      idle(9);
      step(1'b1, 1'b0, 1'b1, 16'd100);
      idle(5);
      check_eq("count_abort", 32'(last_meas), 32'd9);
      check_eq("aborted_held", 32'(bus.aborted), 32'd1);

      // go held high, interval changed mid-sequence.
      n_starts = 0;
      step(1'b1, 1'b1, 1'b0, 16'd3);
      step(1'b1, 1'b1, 1'b0, 16'd3);
      for (int i = 0; i < 14; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'd7);
      end
      idle(15);
      check_eq("held_go_starts", 32'(n_starts), 32'd2);
      check_eq("count_second", 32'(last_meas), 32'd7);

      // Reset in the middle of a wait.
      last_meas = -1;
      step(1'b1, 1'b1, 1'b0, 16'd50);
      idle(10);
      step(1'b0, 1'b0, 1'b0, 16'd50);
      idle(60);
      check_eq("no_stop_after_reset", 32'(last_meas), 32'hFFFF_FFFF);
      step(1'b1, 1'b1, 1'b0, 16'd2);
      idle(6);
      check_eq("count_after_reset", 32'(last_meas), 32'd2);

      // Random traffic with short intervals, aborts and rare resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
              W'($urandom_range(0, 12)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_interval_pulse_gen
